// File: rtl/ldpc_ber_pkg.sv
// ldpc_ber_pkg: shared states, stop reasons and sizes for the LDPC BER run controller.
package ldpc_ber_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  localparam logic [1:0] STOP_NONE   = 2'd0;
  localparam logic [1:0] STOP_FRAMES = 2'd1;
  localparam logic [1:0] STOP_ERRORS = 2'd2;
  localparam logic [1:0] STOP_ABORT  = 2'd3;
  localparam int CLEAR_CYCLES = 2;
  localparam int MASK_W = 128;
  localparam int LAST_BITS_W = 7;
endpackage

// File: rtl/ldpc_ber_last_mask.sv
// ldpc_ber_last_mask: registered decoder from last_bits to the final-beat valid-bit mask.
module ldpc_ber_last_mask
  import ldpc_ber_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   load,
  input  logic [LAST_BITS_W-1:0] last_bits,
  output logic [MASK_W-1:0]      last_mask
);
  logic [MASK_W-1:0] mask_q, mask_d;
  // last_bits = 0 encodes a full 128-bit final beat
  always_comb mask_d = !load ? mask_q :
                       (last_bits == '0) ? '1 : (MASK_W'(1) << last_bits) - MASK_W'(1);
  always_ff @(posedge clk) begin
    if (!resetn) mask_q <= '1;
    else mask_q <= mask_d;
  end
  assign last_mask = mask_q;
endmodule

// File: rtl/ldpc_ber_run_ctrl.sv
// ldpc_ber_run_ctrl: sequences one BER run (clear, request, drain, report); error-limit stop under LDPC_BER_ERROR_LIMIT_EN.
module ldpc_ber_run_ctrl
  import ldpc_ber_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [63:0]            frame_limit,
  input  logic [63:0]            error_limit,
  input  logic [LAST_BITS_W-1:0] last_bits,
  output logic                   frame_req_valid,
  input  logic                   frame_req_ready,
  input  logic                   mon_tvalid,
  input  logic                   mon_tready,
  input  logic                   mon_tlast,
  output logic                   ber_resetn,
  input  logic                   ber_active,
  input  logic [63:0]            bit_errors,
  output logic [MASK_W-1:0]      last_mask,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             stop_reason,
  output logic [63:0]            frames_done
);
  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);
  state_t      state_q, state_d;
  logic [63:0] issued_q, issued_d, frames_q, frames_d, frame_limit_q, frame_limit_d;
  logic [3:0]  out_q, out_d;
  logic [1:0]  stop_q, stop_d, clr_cnt_q, clr_cnt_d;
  logic        quiet_q, quiet_d, ber_resetn_q, ber_resetn_d;
  logic        valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic        start_acc, fire, comp_eff, drain_idle, err_hit;
  assign start_acc  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign fire       = valid_q && frame_req_ready;
  // completions with nothing outstanding are spurious and dropped
  assign comp_eff   = mon_tvalid && mon_tready && mon_tlast && out_q != '0;
  assign drain_idle = out_q == '0 && !ber_active;
`ifdef LDPC_BER_ERROR_LIMIT_EN
  logic [63:0] error_limit_q, error_limit_d;
  assign error_limit_d = start_acc ? error_limit : error_limit_q;
  assign err_hit = |error_limit_q && bit_errors >= error_limit_q;
  always_ff @(posedge clk) begin
    if (!resetn) error_limit_q <= '0;
    else error_limit_q <= error_limit_d;
  end
`else
  logic unused_err;
  assign unused_err = ^{error_limit, bit_errors};
  assign err_hit = 1'b0;
`endif
  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    out_d         = out_q;
    frames_d      = frames_q;
    stop_d        = stop_q;
    clr_cnt_d     = clr_cnt_q;
    quiet_d       = 1'b0;
    ber_resetn_d  = 1'b1;
    frame_limit_d = frame_limit_q;
    if (state_q == ST_RUN || state_q == ST_DRAIN) begin
      issued_d = issued_q + 64'(fire);
      out_d    = out_q + 4'(fire) - 4'(comp_eff);
      frames_d = frames_q + 64'(comp_eff);
    end
    case (state_q)
      ST_IDLE, ST_DONE: if (start_acc) begin
        state_d       = ST_CLEAR;
        issued_d      = '0;
        out_d         = '0;
        frames_d      = '0;
        stop_d        = STOP_NONE;
        clr_cnt_d     = '0;
        ber_resetn_d  = 1'b0;
        frame_limit_d = frame_limit;
      end
      ST_CLEAR: begin
        clr_cnt_d    = clr_cnt_q + 2'd1;
        ber_resetn_d = 1'b0;
        if (abort) begin
          state_d      = ST_DONE;
          stop_d       = STOP_ABORT;
          ber_resetn_d = 1'b1;
        end else if (clr_cnt_q == 2'(CLEAR_CYCLES - 1)) begin
          ber_resetn_d = 1'b1;
          state_d      = (frame_limit_q == '0) ? ST_DONE : ST_RUN;
          stop_d       = (frame_limit_q == '0) ? STOP_FRAMES : STOP_NONE;
        end
      end
      ST_RUN: begin
        stop_d  = abort ? STOP_ABORT : err_hit ? STOP_ERRORS :
                  (frames_q == frame_limit_q) ? STOP_FRAMES : STOP_NONE;
        state_d = (stop_d != STOP_NONE) ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        quiet_d = drain_idle;
        state_d = (drain_idle && quiet_q) ? ST_DONE : ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = state_d == ST_RUN && issued_d < frame_limit_q && out_d < MAX_O;
    busy_d  = state_d == ST_CLEAR || state_d == ST_RUN || state_d == ST_DRAIN;
    done_d  = state_d == ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      issued_q      <= '0;
      out_q         <= '0;
      frames_q      <= '0;
      stop_q        <= STOP_NONE;
      clr_cnt_q     <= '0;
      quiet_q       <= 1'b0;
      ber_resetn_q  <= 1'b1;
      frame_limit_q <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      out_q         <= out_d;
      frames_q      <= frames_d;
      stop_q        <= stop_d;
      clr_cnt_q     <= clr_cnt_d;
      quiet_q       <= quiet_d;
      ber_resetn_q  <= ber_resetn_d;
      frame_limit_q <= frame_limit_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end
  ldpc_ber_last_mask u_mask (
    .clk       (clk),
    .resetn    (resetn),
    .load      (start_acc),
    .last_bits (last_bits),
    .last_mask (last_mask)
  );
  assign frame_req_valid = valid_q;
  assign ber_resetn      = ber_resetn_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign stop_reason     = stop_q;
  assign frames_done     = frames_q;
endmodule

// File: tb/tb_ldpc_ber_run_ctrl.sv
// tb_ldpc_ber_run_ctrl: directed self-checking bench for ldpc_ber_run_ctrl.
module tb_ldpc_ber_run_ctrl;
  logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [63:0]  frame_limit = '0, error_limit = '0, bit_errors = '0, frames_done;
  logic [6:0]   last_bits = '0;
  logic         frame_req_valid, frame_req_ready = 1'b0;
  logic         mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic         ber_resetn, ber_active = 1'b0, busy, done;
  logic [127:0] last_mask;
  logic [1:0]   stop_reason;
  int total = 0, bad = 0, n_req = 0, n_comp = 0;
  localparam logic [127:0] ONES = '1;

  ldpc_ber_run_ctrl #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .frame_limit(frame_limit), .error_limit(error_limit), .last_bits(last_bits),
    .frame_req_valid(frame_req_valid), .frame_req_ready(frame_req_ready),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .ber_resetn(ber_resetn), .ber_active(ber_active), .bit_errors(bit_errors),
    .last_mask(last_mask), .busy(busy), .done(done),
    .stop_reason(stop_reason), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // one clock; counts completions (only when one is outstanding) and request handshakes
  task automatic cyc(input logic comp);
    {mon_tvalid, mon_tready, mon_tlast} = {3{comp}};
    if (comp && n_req > n_comp) n_comp++;
    if (frame_req_valid && frame_req_ready) n_req++;
    @(posedge clk); #1;
    {mon_tvalid, mon_tready, mon_tlast} = 3'b000;
  endtask

  task automatic complete_one();
    for (int i = 0; i < 50 && n_req <= n_comp; i++) cyc(1'b0);
    if (n_req <= n_comp) chk("comp_wait", 0, 1);
    else cyc(1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !done; i++) cyc(1'b0);
    chk("done_wait", done, 1);
  endtask

  task automatic do_start(input logic [63:0] fl, input logic [63:0] el, input logic [6:0] lb);
    frame_limit = fl; error_limit = el; last_bits = lb;
    n_req = 0; n_comp = 0;
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    frame_limit = '1; error_limit = '1; last_bits = 7'd3;
  endtask

  initial begin
    cyc(1'b0); cyc(1'b0);
    chk("rst_valid", frame_req_valid, 0);
    chk("rst_berrn", ber_resetn, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stop", stop_reason, 0);
    chk("rst_mask", last_mask, ONES);
    chk("rst_frames", frames_done, 0);
    resetn = 1'b1;
    cyc(1'b0);

    // frame limit 3, completion every 10 cycles
    frame_req_ready = 1'b1;
    do_start(3, 0, 0);
    cyc(1'b0); cyc(1'b0);
    chk("t1_valid_c3", frame_req_valid, 1);
    repeat (3) begin
      repeat (9) cyc(1'b0);
      complete_one();
    end
    wait_done();
    chk("t1_frames", frames_done, 3);
    chk("t1_stop", stop_reason, 1);
    chk("t1_mask", last_mask, ONES);
    chk("t1_reqs", n_req, 3);
    chk("t1_busy", busy, 0);

    // last_bits 5 and clear window
    do_start(1, 0, 5);
    chk("t2_berrn_c1", ber_resetn, 0);
    chk("t2_busy_c1", busy, 1);
    chk("t2_mask", last_mask, 128'h1f);
    cyc(1'b0);
    chk("t2_berrn_c2", ber_resetn, 0);
    chk("t2_valid_c2", frame_req_valid, 0);
    cyc(1'b0);
    chk("t2_berrn_c3", ber_resetn, 1);
    chk("t2_valid_c3", frame_req_valid, 1);
    complete_one();
    wait_done();
    chk("t2_frames", frames_done, 1);
    chk("t2_stop", stop_reason, 1);

    // error limit 50, counter jumps to 64 after frame 7
    do_start(100, 50, 0);
    cyc(1'b0); cyc(1'b0);
    repeat (7) begin cyc(1'b0); complete_one(); end
    chk("t3_frames7", frames_done, 7);
    bit_errors = 64'd64; ber_active = 1'b1;
    cyc(1'b0);
`ifdef LDPC_BER_ERROR_LIMIT_EN
    chk("t3_valid_drop", frame_req_valid, 0);
    chk("t3_stop", stop_reason, 2);
`else
    chk("t3_no_err_stop", stop_reason, 0);
    chk("t3_busy", busy, 1);
    abort = 1'b1;
    cyc(1'b0);
    abort = 1'b0;
    chk("t3_valid_drop", frame_req_valid, 0);
    chk("t3_stop", stop_reason, 3);
`endif
    repeat (3) cyc(1'b0);
    chk("t3_req_frozen", frame_req_valid, 0);
    for (int i = 0; i < 8 && n_req > n_comp; i++) complete_one();
    repeat (3) cyc(1'b0);
    chk("t3_hold_active", done, 0);
    ber_active = 1'b0;
    cyc(1'b0);
    chk("t3_quiet1", done, 0);
    cyc(1'b0);
    chk("t3_done", done, 1);
    chk("t3_frames", frames_done, n_comp);
    bit_errors = '0;

    // outstanding window of 4; start while busy ignored
    do_start(20, 0, 0);
    cyc(1'b0); cyc(1'b0);
    repeat (10) cyc(1'b0);
    chk("t4_reqs4", n_req, 4);
    chk("t4_valid_full", frame_req_valid, 0);
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    chk("t4_start_busy_berrn", ber_resetn, 1);
    chk("t4_start_busy_busy", busy, 1);
    complete_one();
    repeat (6) cyc(1'b0);
    chk("t4_reqs5", n_req, 5);
    chk("t4_frames1", frames_done, 1);
    abort = 1'b1;
    cyc(1'b0);
    abort = 1'b0;
    repeat (4) complete_one();
    wait_done();
    chk("t4_stop", stop_reason, 3);
    chk("t4_frames", frames_done, 5);

    // abort with 2 outstanding, plus a spurious completion
    frame_req_ready = 1'b0;
    do_start(10, 0, 0);
    cyc(1'b0); cyc(1'b0);
    cyc(1'b1);
    chk("t5_spurious", frames_done, 0);
    frame_req_ready = 1'b1;
    cyc(1'b0); cyc(1'b0);
    frame_req_ready = 1'b0;
    chk("t5_reqs2", n_req, 2);
    abort = 1'b1;
    cyc(1'b0);
    abort = 1'b0;
    chk("t5_valid_drop", frame_req_valid, 0);
    chk("t5_stop", stop_reason, 3);
    complete_one(); complete_one();
    wait_done();
    chk("t5_frames", frames_done, 2);

    // frame limit 0 goes straight to DONE at cycle 3
    do_start(0, 0, 0);
    cyc(1'b0);
    chk("t6_done_c2", done, 0);
    cyc(1'b0);
    chk("t6_done_c3", done, 1);
    chk("t6_stop", stop_reason, 1);
    chk("t6_frames", frames_done, 0);
    chk("t6_reqs", n_req, 0);

    // reset mid-run
    frame_req_ready = 1'b1;
    do_start(50, 0, 9);
    repeat (5) cyc(1'b0);
    resetn = 1'b0;
    cyc(1'b0);
    chk("t7_valid", frame_req_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_frames", frames_done, 0);
    chk("t7_mask", last_mask, ONES);
    chk("t7_berrn", ber_resetn, 1);
    resetn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
